// File: rtl/poly_mac_seq.sv
// poly_mac_seq: streams packed two-lane coefficient words through an external
// combinational modular MAC. For each word index i it reads A[i], B[i], C[i]
// over a single-outstanding req/gnt/rvalid memory port, lets the MAC settle
// for one cycle, and writes the lane-masked result to R[i].
// Optional build macro POLY_MAC_SEQ_CYCLE_CNT_EN adds a saturating busy-cycle
// counter on cycles_o.
module poly_mac_seq #(
  parameter int LOG2_Q = 16,
  parameter int ADDR_W = 16
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              start_i,
  input  logic [ADDR_W-1:0] base_a_i,
  input  logic [ADDR_W-1:0] base_b_i,
  input  logic [ADDR_W-1:0] base_c_i,
  input  logic [ADDR_W-1:0] base_r_i,
  input  logic [ADDR_W-1:0] len_i,
  output logic              busy_o,
  output logic              done_o,
`ifdef POLY_MAC_SEQ_CYCLE_CNT_EN
  output logic [31:0]       cycles_o,
`endif
  output logic              mem_req_o,
  input  logic              mem_gnt_i,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [31:0]       mem_wdata_o,
  input  logic              mem_rvalid_i,
  input  logic [31:0]       mem_rdata_i,
  output logic [31:0]       mac_in1_o,
  output logic [31:0]       mac_in2_o,
  output logic [31:0]       mac_in3_o,
  input  logic [31:0]       mac_result_i
);

  // Bits of each 16-bit lane slot that carry coefficient data.
  localparam logic [15:0] LANE_MASK = 16'((33'd1 << LOG2_Q) - 33'd1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RD_A = 3'd1,
    S_RD_B = 3'd2,
    S_RD_C = 3'd3,
    S_CALC = 3'd4,
    S_WR   = 3'd5,
    S_FIN  = 3'd6
  } state_t;

  state_t            r_state;
  logic              r_resp;     // 1 = access granted, waiting for rvalid
  logic              r_busy;
  logic              r_done;
  logic              r_req;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_wdata;
  logic [31:0]       r_op_a;
  logic [31:0]       r_op_b;
  logic [31:0]       r_op_c;
  logic [ADDR_W-1:0] r_idx;
  logic [ADDR_W-1:0] r_len;
  logic [ADDR_W-1:0] r_base_a;
  logic [ADDR_W-1:0] r_base_b;
  logic [ADDR_W-1:0] r_base_c;
  logic [ADDR_W-1:0] r_base_r;

  // Addresses wrap modulo 2^ADDR_W through plain truncating addition.
  logic [ADDR_W-1:0] w_addr_b;
  logic [ADDR_W-1:0] w_addr_c;
  logic [ADDR_W-1:0] w_addr_r;
  logic [ADDR_W-1:0] w_addr_a_next;
  logic              w_last;
  logic [31:0]       w_result;

  assign w_addr_b      = r_base_b + r_idx;
  assign w_addr_c      = r_base_c + r_idx;
  assign w_addr_r      = r_base_r + r_idx;
  assign w_addr_a_next = r_base_a + r_idx + ADDR_W'(1);
  assign w_last        = (r_idx == (r_len - ADDR_W'(1)));
  assign w_result      = mac_result_i & {LANE_MASK, LANE_MASK};

  // Sequencer FSM; every port-facing signal is a register updated here.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state  <= S_IDLE;
      r_resp   <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_req    <= 1'b0;
      r_we     <= 1'b0;
      r_addr   <= '0;
      r_wdata  <= 32'd0;
      r_op_a   <= 32'd0;
      r_op_b   <= 32'd0;
      r_op_c   <= 32'd0;
      r_idx    <= '0;
      r_len    <= '0;
      r_base_a <= '0;
      r_base_b <= '0;
      r_base_c <= '0;
      r_base_r <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start_i) begin
            r_base_a <= base_a_i;
            r_base_b <= base_b_i;
            r_base_c <= base_c_i;
            r_base_r <= base_r_i;
            r_len    <= len_i;
            r_idx    <= '0;
            r_resp   <= 1'b0;
            if (len_i == '0) begin
              r_state <= S_FIN;
              r_done  <= 1'b1;
              r_busy  <= 1'b0;
            end else begin
              r_state <= S_RD_A;
              r_busy  <= 1'b1;
              r_req   <= 1'b1;
              r_we    <= 1'b0;
              r_addr  <= base_a_i;
            end
          end
        end
        S_RD_A, S_RD_B, S_RD_C: begin
          if (!r_resp) begin
            // Request phase: hold addr/we stable until granted.
            if (mem_gnt_i) begin
              r_req  <= 1'b0;
              r_resp <= 1'b1;
            end
          end else if (mem_rvalid_i) begin
            r_resp <= 1'b0;
            if (r_state == S_RD_A) begin
              r_op_a  <= mem_rdata_i;
              r_state <= S_RD_B;
              r_req   <= 1'b1;
              r_addr  <= w_addr_b;
            end else if (r_state == S_RD_B) begin
              r_op_b  <= mem_rdata_i;
              r_state <= S_RD_C;
              r_req   <= 1'b1;
              r_addr  <= w_addr_c;
            end else begin
              r_op_c  <= mem_rdata_i;
              r_state <= S_CALC;
            end
          end
        end
        S_CALC: begin
          // Operands have been stable for a full cycle; take the MAC result.
          r_wdata <= w_result;
          r_state <= S_WR;
          r_req   <= 1'b1;
          r_we    <= 1'b1;
          r_addr  <= w_addr_r;
        end
        S_WR: begin
          if (!r_resp) begin
            if (mem_gnt_i) begin
              r_req  <= 1'b0;
              r_resp <= 1'b1;
            end
          end else if (mem_rvalid_i) begin
            r_resp <= 1'b0;
            r_we   <= 1'b0;
            if (w_last) begin
              r_state <= S_FIN;
              r_done  <= 1'b1;
              r_busy  <= 1'b0;
            end else begin
              r_idx   <= r_idx + ADDR_W'(1);
              r_state <= S_RD_A;
              r_req   <= 1'b1;
              r_addr  <= w_addr_a_next;
            end
          end
        end
        S_FIN: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
          r_resp  <= 1'b0;
          r_busy  <= 1'b0;
          r_req   <= 1'b0;
          r_we    <= 1'b0;
        end
      endcase
    end
  end

`ifdef POLY_MAC_SEQ_CYCLE_CNT_EN
  logic [31:0] r_cycles;

  // Saturating count of busy cycles, cleared when a start is accepted.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_cycles <= 32'd0;
    end else if ((r_state == S_IDLE) && start_i) begin
      r_cycles <= 32'd0;
    end else if (r_busy && (r_cycles != 32'hFFFF_FFFF)) begin
      r_cycles <= r_cycles + 32'd1;
    end
  end

  assign cycles_o = r_cycles;
`endif

  assign busy_o      = r_busy;
  assign done_o      = r_done;
  assign mem_req_o   = r_req;
  assign mem_we_o    = r_we;
  assign mem_addr_o  = r_addr;
  assign mem_wdata_o = r_wdata;
  assign mac_in1_o   = r_op_a;
  assign mac_in2_o   = r_op_b;
  assign mac_in3_o   = r_op_c;

endmodule

// File: tb/tb_poly_mac_seq.sv
// Self-checking bench for poly_mac_seq: a word memory with random gnt/rvalid
// stalls, a lane-wise MAC stub, and a reference model that predicts the full
// access sequence (address, direction, write data) of each run.
module tb_poly_mac_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [15:0] base_a, base_b, base_c, base_r, len;
  logic        busy, done;
  logic        req, gnt, we, rvalid;
  logic [15:0] addr;
  logic [31:0] wdata, rdata;
  logic [31:0] in1, in2, in3, result;
`ifdef POLY_MAC_SEQ_CYCLE_CNT_EN
  logic [31:0] cycles;
`endif

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  poly_mac_seq #(.LOG2_Q(16), .ADDR_W(16)) dut (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start),
    .base_a_i(base_a), .base_b_i(base_b), .base_c_i(base_c), .base_r_i(base_r),
    .len_i(len), .busy_o(busy), .done_o(done),
`ifdef POLY_MAC_SEQ_CYCLE_CNT_EN
    .cycles_o(cycles),
`endif
    .mem_req_o(req), .mem_gnt_i(gnt), .mem_we_o(we), .mem_addr_o(addr),
    .mem_wdata_o(wdata), .mem_rvalid_i(rvalid), .mem_rdata_i(rdata),
    .mac_in1_o(in1), .mac_in2_o(in2), .mac_in3_o(in3), .mac_result_i(result)
  );

  // Per-lane (a*b + c) mod 2^16.
  function automatic logic [31:0] mac_ref(input logic [31:0] a, input logic [31:0] b,
                                          input logic [31:0] c);
    logic [31:0] lo, hi;
    lo = {16'd0, a[15:0]} * {16'd0, b[15:0]} + {16'd0, c[15:0]};
    hi = {16'd0, a[31:16]} * {16'd0, b[31:16]} + {16'd0, c[31:16]};
    return {hi[15:0], lo[15:0]};
  endfunction

  assign result = mac_ref(in1, in2, in3);

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic [15:0] a;
    logic        w;
    logic [31:0] d;
  } acc_t;

  acc_t        exp_q[$];
  logic [31:0] mem [0:65535];

  // Controls written only by the main process.
  bit zero_wait = 1'b1;
  bit hold_wr   = 1'b0;
  int poke_req  = 0;

  // Memory responder and per-cycle protocol/access checker.
  int          poke_seen = 0;
  bit          pend = 1'b0;
  int          rdly = 0;
  int          gwait = 0;
  logic [31:0] pdata = 32'd0;
  bit          prev_wait = 1'b0;
  logic        p_we;
  logic [15:0] p_addr;
  logic [31:0] p_wdata;

  initial begin
    acc_t e;
    gnt = 1'b0; rvalid = 1'b0; rdata = 32'd0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        pend = 1'b0; prev_wait = 1'b0; gnt = 1'b0; rvalid = 1'b0; gwait = 0;
        continue;
      end
      rvalid = 1'b0;
      if (pend) begin
        if (rdly == 0) begin
          rvalid = 1'b1; rdata = pdata; pend = 1'b0;
        end else begin
          rdly--;
        end
      end else if (poke_req != poke_seen) begin
        poke_seen = poke_req; rvalid = 1'b1; rdata = $urandom;
      end else if (!zero_wait && ($urandom_range(7) == 0)) begin
        rvalid = 1'b1; rdata = $urandom;
      end
      if (prev_wait)
        check("req_stable", {req, we, addr, wdata}, {1'b1, p_we, p_addr, p_wdata});
      gnt = 1'b0; prev_wait = 1'b0;
      if (req) begin
        check("one_outstanding", {63'd0, pend}, 64'd0);
        if (gwait > 0 || (hold_wr && we)) begin
          if (gwait > 0) gwait--;
          prev_wait = 1'b1; p_we = we; p_addr = addr; p_wdata = wdata;
        end else begin
          gnt = 1'b1;
          if (exp_q.size() == 0) begin
            tests++; fails++;
            $display("FAIL unexpected_access: got addr %0h we %0b expected none", addr, we);
          end else begin
            e = exp_q.pop_front();
            check("acc_addr", {48'd0, addr}, {48'd0, e.a});
            check("acc_we", {63'd0, we}, {63'd0, e.w});
            if (e.w) check("acc_wdata", {32'd0, wdata}, {32'd0, e.d});
          end
          if (we) mem[addr] = wdata;
          else    pdata = mem[addr];
          pend  = 1'b1;
          rdly  = zero_wait ? 0 : $urandom_range(5);
          gwait = zero_wait ? 0 : $urandom_range(5);
        end
      end
    end
  end

  // Predict the access sequence from the current memory, honouring aliasing.
  task automatic build_exp(input logic [15:0] ba, bb, bc, br, ln);
    logic [31:0] wk [logic [15:0]];
    logic [15:0] ad [3];
    logic [31:0] v [3];
    logic [15:0] ra;
    exp_q.delete();
    for (int i = 0; i < int'(ln); i++) begin
      ad[0] = ba + 16'(i); ad[1] = bb + 16'(i); ad[2] = bc + 16'(i);
      for (int k = 0; k < 3; k++) begin
        v[k] = wk.exists(ad[k]) ? wk[ad[k]] : mem[ad[k]];
        exp_q.push_back('{a: ad[k], w: 1'b0, d: 32'd0});
      end
      ra = br + 16'(i);
      wk[ra] = mac_ref(v[0], v[1], v[2]);
      exp_q.push_back('{a: ra, w: 1'b1, d: wk[ra]});
    end
  endtask

  // One complete run; lat = cycles from first request to done (or start to done if len=0).
  task automatic run(input logic [15:0] ba, bb, bc, br, ln, input bit zw, input bit poke,
                     output int lat);
    int k, fr;
    bit got;
    build_exp(ba, bb, bc, br, ln);
    zero_wait = zw;
    @(negedge clk);
    base_a = ba; base_b = bb; base_c = bc; base_r = br; len = ln; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    k = 1; fr = -1; got = 1'b0;
    while (k <= 3000) begin
      if (req && fr < 0) fr = k;
      if (done) begin got = 1'b1; break; end
      check("busy_during_run", {63'd0, busy}, 64'd1);
      if (poke && k == 3) begin
        start = 1'b1; base_a = ~ba; base_b = ~bb; base_c = ~bc; base_r = ~br; len = 16'd1;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      k++;
    end
    start = 1'b0;
    lat = -1;
    if (!got) begin
      tests++; fails++;
      $display("FAIL run_timeout: got no done_o expected done within 3000 cycles");
    end else begin
      check("busy_low_at_done", {63'd0, busy}, 64'd0);
      check("all_accesses_seen", 64'(exp_q.size()), 64'd0);
      lat = (fr < 0) ? k : (k - fr);
      if (ln == 16'd0) check("len0_no_req", 64'(fr < 0), 64'd1);
      @(negedge clk);
      check("done_one_cycle", {62'd0, done, busy}, 64'd0);
    end
  endtask

  initial begin
    int lat;
    bit found;
    logic [15:0] ra, rb, rc, rr;
    for (int i = 0; i < 65536; i++) mem[i] = $urandom;
    rst_n = 1'b0; start = 1'b0;
    base_a = 16'd0; base_b = 16'd0; base_c = 16'd0; base_r = 16'd0; len = 16'd0;
    repeat (3) @(negedge clk);
    check("rst_ctrl", {60'd0, busy, done, req, we}, 64'd0);
    check("rst_addr_wdata", {16'd0, addr, wdata}, 64'd0);
    check("rst_operands", {in1 | in2 | in3, 32'd0}, 64'd0);
`ifdef POLY_MAC_SEQ_CYCLE_CNT_EN
    check("rst_cycles", {32'd0, cycles}, 64'd0);
`endif
    #1 rst_n = 1'b1;

    // Pin the reference model with hand-computed values.
    check("model_basic", {32'd0, mac_ref(32'h0003_0002, 32'h0005_0004, 32'h0001_0001)}, 64'h0010_0009);
    check("model_wrap", {32'd0, mac_ref(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_0001)}, 64'h0000_0002);

    // Single word, zero-wait memory.
    mem[16'h0100] = 32'h0003_0002; mem[16'h0200] = 32'h0005_0004; mem[16'h0300] = 32'h0001_0001;
    run(16'h0100, 16'h0200, 16'h0300, 16'h0400, 16'd1, 1'b1, 1'b0, lat);
    check("single_result", {32'd0, mem[16'h0400]}, 64'h0010_0009);
    check("single_latency", 64'(lat), 64'd9);
`ifdef POLY_MAC_SEQ_CYCLE_CNT_EN
    check("cycles_single", {32'd0, cycles}, 64'd9);
`endif

    // Lane wrap.
    mem[16'h0110] = 32'hFFFF_FFFF; mem[16'h0210] = 32'hFFFF_FFFF; mem[16'h0310] = 32'hFFFF_0001;
    run(16'h0110, 16'h0210, 16'h0310, 16'h0410, 16'd1, 1'b1, 1'b0, lat);
    check("wrap_result", {32'd0, mem[16'h0410]}, 64'h0000_0002);

    // Random stalls, random data and bases, len=8; first run also pulses start while busy.
    for (int r = 0; r < 4; r++) begin
      ra = 16'($urandom); rb = 16'($urandom); rc = 16'($urandom); rr = 16'($urandom);
      run(ra, rb, rc, rr, 16'd8, 1'b0, (r == 0), lat);
    end

    // len=0: no memory traffic; done in the cycle after the start cycle.
    run(16'h1234, 16'h2345, 16'h3456, 16'h4567, 16'd0, 1'b1, 1'b0, lat);
    check("len0_done_latency", 64'(lat), 64'd1);
`ifdef POLY_MAC_SEQ_CYCLE_CNT_EN
    check("cycles_len0", {32'd0, cycles}, 64'd0);
`endif

    // In place with address wrap: R aliases A at 0xFFFF, 0x0000.
    mem[16'hFFFF] = 32'h0002_0003; mem[16'h1000] = 32'h0004_0005; mem[16'h2000] = 32'h0001_0001;
    mem[16'h0000] = 32'h0001_0001; mem[16'h1001] = 32'h0007_0007; mem[16'h2001] = 32'h0000_0000;
    run(16'hFFFF, 16'h1000, 16'h2000, 16'hFFFF, 16'd2, 1'b0, 1'b0, lat);
    check("inplace_w0", {32'd0, mem[16'hFFFF]}, 64'h0009_0010);
    check("inplace_w1", {32'd0, mem[16'h0000]}, 64'h0007_0007);

    // Reset while the write request is waiting for grant.
    zero_wait = 1'b1; hold_wr = 1'b1;
    build_exp(16'h0500, 16'h0600, 16'h0700, 16'h0800, 16'd1);
    @(negedge clk);
    base_a = 16'h0500; base_b = 16'h0600; base_c = 16'h0700; base_r = 16'h0800;
    len = 16'd1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 50 && !found; k++) begin
      if (req && we) found = 1'b1;
      else @(negedge clk);
    end
    check("wr_request_reached", {63'd0, found}, 64'd1);
    #2 rst_n = 1'b0;
    #1 check("abort_async", {61'd0, req, busy, done}, 64'd0);
    @(negedge clk);
    @(negedge clk);
    #1 rst_n = 1'b1;
    hold_wr = 1'b0; exp_q.delete(); poke_req++;
    repeat (3) @(negedge clk);
    check("idle_after_abort", {62'd0, req, busy}, 64'd0);
    mem[16'h0500] = 32'h0003_0002; mem[16'h0600] = 32'h0005_0004; mem[16'h0700] = 32'h0001_0001;
    run(16'h0500, 16'h0600, 16'h0700, 16'h0800, 16'd1, 1'b1, 1'b0, lat);
    check("after_abort_result", {32'd0, mem[16'h0800]}, 64'h0010_0009);
    check("after_abort_latency", 64'(lat), 64'd9);
`ifdef POLY_MAC_SEQ_CYCLE_CNT_EN
    check("cycles_after_abort", {32'd0, cycles}, 64'd9);
`endif

    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
